// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response plus the decode handoff.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher with a 2-entry {pc,instr} queue toward decode.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk_i,
  input logic          rst_n_i,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {ISSUE, WAIT, KILL} state_t;

  state_t           state, state_nxt;
  logic [31:0]      fpc, req_pc, redir_tgt;
  logic [1:0][31:0] q_pc, q_instr;
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count;
  logic             resp, bypass, pop, fifo_pop, push, fire;

  assign redir_tgt = bus.redirect_pc & 32'hFFFF_FFFC;
  // A response is kept only if it lands in WAIT with no redirect the same cycle
  assign resp      = (state == WAIT) && bus.imem_rvalid && !bus.redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp && (count == 2'd0);
`else
  assign bypass = 1'b0;
`endif

  assign bus.if_valid = (count != 2'd0) || bypass;
  assign bus.if_instr = bypass ? bus.imem_rdata : q_instr[rd_ptr];
  assign bus.if_pc    = bypass ? req_pc : q_pc[rd_ptr];

  assign pop      = bus.if_valid && bus.id_ready && !bus.redirect;
  assign fifo_pop = pop && !bypass;
  assign push     = resp && !(bypass && bus.id_ready);

  // Issue only if the queue will have room for the response; gated while reset is held
  assign fire = rst_n_i && (state == ISSUE) && !bus.redirect &&
                ((count != 2'd2) || fifo_pop);

  assign bus.imem_req  = fire;
  assign bus.imem_addr = fpc;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ISSUE:   if (fire) state_nxt = WAIT;
      WAIT:    if (bus.imem_rvalid) state_nxt = ISSUE;
               else if (bus.redirect) state_nxt = KILL;
      KILL:    if (bus.imem_rvalid) state_nxt = ISSUE;
      default: state_nxt = ISSUE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ISSUE;
      fpc     <= RESET_PC;
      req_pc  <= RESET_PC;
      q_pc    <= '0;
      q_instr <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      state <= state_nxt;
      if (bus.redirect) begin
        fpc <= redir_tgt;
      end else if (fire) begin
        fpc    <= fpc + 32'd4;
        req_pc <= fpc;
      end
      if (bus.redirect) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          q_pc[wr_ptr]    <= req_pc;
          q_instr[wr_ptr] <= bus.imem_rdata;
          wr_ptr          <= ~wr_ptr;
        end
        if (fifo_pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, fifo_pop};
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against an in-order stream model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if f0 ();
  fetch_unit_if f1 ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(f0));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(f1));

  int n_checks = 0;
  int n_pass   = 0;

`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory for f0: fixed latency chosen at request time
  int          lat = 1;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  always @(negedge clk) begin
    if (f0.imem_req === 1'b1) begin
      pend  = 1;
      paddr = f0.imem_addr;
      cnt   = lat;
    end
  end
  always @(posedge clk) begin
    #1;
    f0.imem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        f0.imem_rvalid = 1'b1;
        f0.imem_rdata  = memf(paddr);
        pend = 0;
      end
    end
  end

  // Memory for f1: always one cycle
  logic        r1 = 1'b0;
  logic [31:0] a1 = '0;
  always @(negedge clk) begin
    r1 = (f1.imem_req === 1'b1);
    a1 = f1.imem_addr;
  end
  always @(posedge clk) begin
    #1;
    f1.imem_rvalid = r1;
    f1.imem_rdata  = memf(a1);
  end

  initial begin
    f1.id_ready    = 1'b1;
    f1.redirect    = 1'b0;
    f1.redirect_pc = '0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset(input int l, input logic rdy);
    @(posedge clk); #1;
    rst_n = 1'b0; f0.redirect = 1'b0; f0.redirect_pc = '0; f0.id_ready = rdy; lat = l;
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Expects n in-order deliveries starting at pc 'start' from the current negedge on
  task automatic expect_stream(input logic [31:0] start, input int n, input string nm);
    logic [31:0] e;
    int got;
    e = start; got = 0;
    for (int i = 0; i < 60 && got < n; i++) begin
      if (i > 0) begin @(posedge clk); @(negedge clk); end
      if (f0.if_valid === 1'b1 && f0.id_ready === 1'b1) begin
        n_checks++;
        if (f0.if_pc !== e) $display("FAIL %s_pc: got %h exp %h", nm, f0.if_pc, e);
        else n_pass++;
        n_checks++;
        if (f0.if_instr !== memf(e)) $display("FAIL %s_instr: got %h exp %h", nm, f0.if_instr, memf(e));
        else n_pass++;
        e += 32'd4; got++;
      end
    end
    n_checks++;
    if (got !== n) $display("FAIL %s_count: got %0d exp %0d", nm, got, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; f0.id_ready = 1'b1; f0.redirect = 1'b0; f0.redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (f0.if_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", f0.if_valid); else n_pass++;
    n_checks++; if (f0.if_instr !== 32'h0) $display("FAIL rst_instr: got %h exp 0", f0.if_instr); else n_pass++;
    n_checks++; if (f0.if_pc !== 32'h0) $display("FAIL rst_pc: got %h exp 0", f0.if_pc); else n_pass++;
    n_checks++; if (f0.imem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", f0.imem_req); else n_pass++;
    n_checks++; if (f0.imem_addr !== 32'h0) $display("FAIL rst_addr: got %h exp 0", f0.imem_addr); else n_pass++;
    n_checks++; if (f1.imem_addr !== 32'hFFFF_FFF8) $display("FAIL rst_addr1: got %h exp fffffff8", f1.imem_addr); else n_pass++;
    n_checks++; if (f1.imem_req !== 1'b0) $display("FAIL rst_req1: got %b exp 0", f1.imem_req); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (f0.imem_req !== 1'b1) $display("FAIL first_req: got %b exp 1", f0.imem_req); else n_pass++;
    n_checks++; if (f0.imem_addr !== 32'h0) $display("FAIL first_addr: got %h exp 0", f0.imem_addr); else n_pass++;
  endtask

  task automatic test_latency();
    int cyc;
    do_reset(1, 1'b1);
    n_checks++; if (f0.imem_req !== 1'b1) $display("FAIL lat_req: got %b exp 1", f0.imem_req); else n_pass++;
    cyc = 0;
    while (f0.if_valid !== 1'b1 && cyc < 10) begin
      @(posedge clk); @(negedge clk); cyc++;
    end
    n_checks++; if (cyc !== FIRST_LAT) $display("FAIL first_valid_latency: got %0d exp %0d", cyc, FIRST_LAT); else n_pass++;
    expect_stream(32'h0, 3, "lat_stream");
  endtask

  task automatic test_stall();
    int nreq;
    do_reset(1, 1'b0);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (f0.imem_req === 1'b1) nreq++;
      if (f0.if_valid === 1'b1) begin
        n_checks++; if (f0.if_pc !== 32'h0) $display("FAIL stall_pc: got %h exp 0", f0.if_pc); else n_pass++;
        n_checks++; if (f0.if_instr !== memf(32'h0)) $display("FAIL stall_instr: got %h exp %h", f0.if_instr, memf(32'h0)); else n_pass++;
      end
      @(posedge clk); @(negedge clk);
    end
    n_checks++; if (nreq !== 2) $display("FAIL stall_reqs: got %0d exp 2", nreq); else n_pass++;
    n_checks++; if (f0.if_valid !== 1'b1) $display("FAIL stall_valid: got %b exp 1", f0.if_valid); else n_pass++;
    @(posedge clk); #1; f0.id_ready = 1'b1;
    @(negedge clk);
    expect_stream(32'h0, 3, "stall_release");
  endtask

  task automatic test_redirect_kill();
    int n;
    bit seen;
    do_reset(3, 1'b1);
    n_checks++; if (f0.imem_addr !== 32'h0) $display("FAIL kill_first_addr: got %h exp 0", f0.imem_addr); else n_pass++;
    @(posedge clk); #1; f0.redirect = 1'b1; f0.redirect_pc = 32'h0000_0103; f0.id_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (f0.imem_req !== 1'b0) $display("FAIL kill_redir_req: got %b exp 0", f0.imem_req); else n_pass++;
    @(posedge clk); #1; f0.redirect = 1'b0; f0.id_ready = 1'b1;
    @(negedge clk);
    n = 0; seen = 0;
    while (f0.imem_req !== 1'b1 && n < 10) begin
      if (f0.imem_rvalid === 1'b1) seen = 1;
      n_checks++; if (f0.if_valid !== 1'b0) $display("FAIL kill_stale_valid: got %b exp 0", f0.if_valid); else n_pass++;
      @(posedge clk); @(negedge clk); n++;
    end
    n_checks++; if (f0.imem_req !== 1'b1) $display("FAIL kill_next_req: got %b exp 1", f0.imem_req); else n_pass++;
    n_checks++; if (f0.imem_addr !== 32'h0000_0100) $display("FAIL kill_next_addr: got %h exp 00000100", f0.imem_addr); else n_pass++;
    n_checks++; if (seen !== 1'b1) $display("FAIL kill_waited_stale: got %b exp 1", seen); else n_pass++;
    expect_stream(32'h0000_0100, 2, "kill_stream");
  endtask

  task automatic test_redirect_coincident();
    do_reset(2, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1; f0.redirect = 1'b1; f0.redirect_pc = 32'h0000_0040;
    @(negedge clk);
    n_checks++; if (f0.imem_req !== 1'b0) $display("FAIL coin_req: got %b exp 0", f0.imem_req); else n_pass++;
    n_checks++; if (f0.if_valid !== 1'b0) $display("FAIL coin_valid_now: got %b exp 0", f0.if_valid); else n_pass++;
    @(posedge clk); #1; f0.redirect = 1'b0;
    @(negedge clk);
    n_checks++; if (f0.if_valid !== 1'b0) $display("FAIL coin_valid_next: got %b exp 0", f0.if_valid); else n_pass++;
    n_checks++; if (f0.imem_req !== 1'b1) $display("FAIL coin_next_req: got %b exp 1", f0.imem_req); else n_pass++;
    n_checks++; if (f0.imem_addr !== 32'h0000_0040) $display("FAIL coin_next_addr: got %h exp 00000040", f0.imem_addr); else n_pass++;
    expect_stream(32'h0000_0040, 2, "coin_stream");
  endtask

  task automatic test_reset_pc_wrap();
    logic [31:0] addrs [3];
    int k;
    do_reset(1, 1'b1);
    k = 0;
    for (int i = 0; i < 12 && k < 3; i++) begin
      if (f1.imem_req === 1'b1) begin addrs[k] = f1.imem_addr; k++; end
      @(posedge clk); @(negedge clk);
    end
    n_checks++; if (k !== 3) $display("FAIL wrap_count: got %0d exp 3", k); else n_pass++;
    if (k == 3) begin
      n_checks++; if (addrs[0] !== 32'hFFFF_FFF8) $display("FAIL wrap_a0: got %h exp fffffff8", addrs[0]); else n_pass++;
      n_checks++; if (addrs[1] !== 32'hFFFF_FFFC) $display("FAIL wrap_a1: got %h exp fffffffc", addrs[1]); else n_pass++;
      n_checks++; if (addrs[2] !== 32'h0000_0000) $display("FAIL wrap_a2: got %h exp 00000000", addrs[2]); else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    do_reset(3, 1'b1);
    @(posedge clk); #1; f0.redirect = 1'b1; f0.redirect_pc = 32'h0000_0200; f0.id_ready = 1'b0;
    @(posedge clk); #1; f0.redirect = 1'b0; f0.id_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (f0.imem_req !== 1'b1 && n < 10) begin @(posedge clk); @(negedge clk); n++; end
    n_checks++; if (f0.imem_addr !== 32'h0000_0200) $display("FAIL mid_req_addr: got %h exp 00000200", f0.imem_addr); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b0; lat = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (f0.if_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b exp 0", f0.if_valid); else n_pass++;
      @(posedge clk);
    end
    #1; rst_n = 1'b1;
    @(negedge clk);
    expect_stream(32'h0, 2, "mid_stream");
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_req;
    bit outst, prev_redir;
    int delivered;
    do_reset(1, 1'b1);
    exp_pc = 32'h0; exp_req = 32'h0; outst = 0; prev_redir = 0; delivered = 0;
    for (int c = 0; c < 600; c++) begin
      if (prev_redir) begin
        n_checks++; if (f0.if_valid !== 1'b0) $display("FAIL rnd_post_redir_valid: got %b exp 0", f0.if_valid); else n_pass++;
      end
      n_checks++;
      if (f0.imem_req === 1'b1 && (outst || f0.imem_rvalid === 1'b1 || f0.redirect === 1'b1))
        $display("FAIL rnd_illegal_req: got 1 exp 0 (cycle %0d)", c);
      else n_pass++;
      if (f0.imem_rvalid === 1'b1) outst = 0;
      if (f0.imem_req === 1'b1) begin
        n_checks++; if (f0.imem_addr !== exp_req) $display("FAIL rnd_req_addr: got %h exp %h", f0.imem_addr, exp_req); else n_pass++;
        exp_req += 32'd4; outst = 1;
      end
      if (f0.if_valid === 1'b1 && f0.id_ready === 1'b1) begin
        n_checks++; if (f0.if_pc !== exp_pc) $display("FAIL rnd_pc: got %h exp %h", f0.if_pc, exp_pc); else n_pass++;
        n_checks++; if (f0.if_instr !== memf(exp_pc)) $display("FAIL rnd_instr: got %h exp %h", f0.if_instr, memf(exp_pc)); else n_pass++;
        exp_pc += 32'd4; delivered++;
      end
      if (f0.redirect === 1'b1) begin
        exp_pc  = f0.redirect_pc & 32'hFFFF_FFFC;
        exp_req = exp_pc;
      end
      prev_redir = (f0.redirect === 1'b1);
      @(posedge clk); #1;
      lat = $urandom_range(1, 3);
      f0.id_ready = ($urandom_range(0, 9) < 7);
      f0.redirect = ($urandom_range(0, 19) == 0);
      if (f0.redirect) begin
        f0.id_ready    = 1'b0;
        f0.redirect_pc = $urandom;
      end
      @(negedge clk);
    end
    n_checks++; if (delivered < 20) $display("FAIL rnd_throughput: got %0d exp >=20", delivered); else n_pass++;
  endtask

  initial begin
    f0.id_ready = 1'b0; f0.redirect = 1'b0; f0.redirect_pc = '0;
    test_reset();
    test_latency();
    test_stall();
    test_redirect_kill();
    test_redirect_coincident();
    test_reset_pc_wrap();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
